// File: rtl/register_file_16bit_pkg.sv
// register_file_16bit_pkg: shared register-file widths and the hardwired-zero register index
package register_file_16bit_pkg;
    localparam int RF_DATA_WIDTH = 16;
    localparam int RF_ADDR_WIDTH = 3;
    localparam int RF_NUM_REGS = 2 ** RF_ADDR_WIDTH;
    localparam logic [RF_ADDR_WIDTH-1:0] RF_REG_ZERO = '0;
endpackage

// File: rtl/register_file_16bit_if.sv
// register_file_16bit_if: read/write port bundle between control/datapath (master) and register file (slave)
interface register_file_16bit_if
    import register_file_16bit_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH
);
    logic [ADDR_WIDTH-1:0] read_reg1;
    logic [ADDR_WIDTH-1:0] read_reg2;
    logic [ADDR_WIDTH-1:0] write_reg;
    logic [DATA_WIDTH-1:0] write_data;
    logic reg_write;
    logic [DATA_WIDTH-1:0] read_data1;
    logic [DATA_WIDTH-1:0] read_data2;
    modport master(
        output read_reg1, read_reg2, write_reg, write_data, reg_write,
        input read_data1, read_data2
    );
    modport slave(
        input read_reg1, read_reg2, write_reg, write_data, reg_write,
        output read_data1, read_data2
    );
endinterface

// File: rtl/register_file_16bit_rdport.sv
// register_file_16bit_rdport: combinational read mux with r0 forced to zero and optional write-through
module register_file_16bit_rdport
    import register_file_16bit_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int BYPASS = 0
) (
    input  logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0] i_regs,
    input  logic [ADDR_WIDTH-1:0]                 i_sel,
    input  logic [ADDR_WIDTH-1:0]                 i_wsel,
    input  logic [DATA_WIDTH-1:0]                 i_wdata,
    input  logic                                  i_we,
    output logic [DATA_WIDTH-1:0]                 o_data
);
    logic w_hit;
    assign w_hit = (BYPASS != 0) && i_we && (i_sel == i_wsel) && (i_sel != RF_REG_ZERO);
    assign o_data = w_hit ? i_wdata : i_regs[i_sel*DATA_WIDTH +: DATA_WIDTH];
endmodule

// File: rtl/register_file_16bit.sv
// register_file_16bit: 8 x 16-bit register file, r0 reads as zero, two combinational read ports
module register_file_16bit
    import register_file_16bit_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int BYPASS = 0
) (
    input logic clk,
    input logic reset,
    register_file_16bit_if.slave bus
);
    localparam int NREGS = 2 ** ADDR_WIDTH;
    logic [NREGS*DATA_WIDTH-1:0] w_flat;
    logic w_we;
    assign w_we = bus.reg_write & ~reset;
    // slot 0 has no storage; the read mux sees a constant zero there
    assign w_flat[DATA_WIDTH-1:0] = '0;
    for (genvar g = 1; g < NREGS; g++) begin : g_reg
        logic [DATA_WIDTH-1:0] r_data;
        logic w_en;
        assign w_en = w_we & (bus.write_reg == ADDR_WIDTH'(g));
        always_ff @(posedge clk) begin
            if (reset) r_data <= '0;
            else if (w_en) r_data <= bus.write_data;
        end
        assign w_flat[g*DATA_WIDTH +: DATA_WIDTH] = r_data;
    end
    register_file_16bit_rdport #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .BYPASS(BYPASS)
    ) u_rd1 (
        .i_regs(w_flat),
        .i_sel(bus.read_reg1),
        .i_wsel(bus.write_reg),
        .i_wdata(bus.write_data),
        .i_we(w_we),
        .o_data(bus.read_data1)
    );
    register_file_16bit_rdport #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .BYPASS(BYPASS)
    ) u_rd2 (
        .i_regs(w_flat),
        .i_sel(bus.read_reg2),
        .i_wsel(bus.write_reg),
        .i_wdata(bus.write_data),
        .i_we(w_we),
        .o_data(bus.read_data2)
    );
endmodule

// File: tb/tb_register_file_16bit.sv
// tb_register_file_16bit: drives a BYPASS=0 and a BYPASS=1 instance in lockstep against an array model
module tb_register_file_16bit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    register_file_16bit_if bus0();
    register_file_16bit_if bus1();
    assign bus1.read_reg1 = bus0.read_reg1;
    assign bus1.read_reg2 = bus0.read_reg2;
    assign bus1.write_reg = bus0.write_reg;
    assign bus1.write_data = bus0.write_data;
    assign bus1.reg_write = bus0.reg_write;

    register_file_16bit #(.BYPASS(0)) dut0 (.clk(clk), .reset(rst), .bus(bus0));
    register_file_16bit #(.BYPASS(1)) dut1 (.clk(clk), .reset(rst), .bus(bus1));

    // obs[0]/[1]: no-bypass rd1/rd2, obs[2]/[3]: bypass rd1/rd2
    logic [3:0][15:0] obs;
    assign obs = {bus1.read_data2, bus1.read_data1, bus0.read_data2, bus0.read_data1};

    logic [15:0] m [8];
    int n_chk = 0;
    int n_fail = 0;

    function automatic logic [15:0] exp_rd(input logic [2:0] sel, input bit byp);
        if (sel == 3'd0) return 16'h0000;
        if (byp && bus0.reg_write && !rst && sel == bus0.write_reg) return bus0.write_data;
        return m[sel];
    endfunction

    task automatic step();
        if (rst) for (int i = 1; i < 8; i++) m[i] = 16'h0000;
        else if (bus0.reg_write && bus0.write_reg != 3'd0) m[bus0.write_reg] = bus0.write_data;
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [2:0] r, input logic [15:0] d);
        bus0.reg_write = 1'b1;
        bus0.write_reg = r;
        bus0.write_data = d;
        step();
        bus0.reg_write = 1'b0;
    endtask

    task automatic test_reset();
        for (int r = 1; r < 8; r++) wr_reg(3'(r), 16'hFFFF);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int r = 0; r < 8; r++) begin
            bus0.read_reg1 = 3'(r);
            bus0.read_reg2 = 3'(r);
            #1;
            for (int k = 0; k < 4; k++) begin
                n_chk++;
                if (obs[k] !== 16'h0000) begin
                    n_fail++;
                    $display("FAIL reset r%0d port%0d: got %h want 0000", r, k, obs[k]);
                end
            end
        end
    endtask

    task automatic test_basic();
        logic [15:0] e;
        wr_reg(3'd3, 16'd1001);
        wr_reg(3'd5, 16'd1234);
        bus0.read_reg1 = 3'd3;
        bus0.read_reg2 = 3'd5;
        #1;
        for (int k = 0; k < 4; k++) begin
            e = k[0] ? 16'd1234 : 16'd1001;
            n_chk++;
            if (obs[k] !== e) begin
                n_fail++;
                $display("FAIL basic port%0d: got %0d want %0d", k, obs[k], e);
            end
        end
        n_chk++;
        if (16'(obs[0] + obs[1]) !== 16'd2235) begin
            n_fail++;
            $display("FAIL basic alu_add: got %0d want 2235", 16'(obs[0] + obs[1]));
        end
    endtask

    task automatic test_r0();
        bus0.reg_write = 1'b1;
        bus0.write_reg = 3'd0;
        bus0.write_data = 16'hBEEF;
        bus0.read_reg1 = 3'd0;
        bus0.read_reg2 = 3'd0;
        #1;
        for (int k = 0; k < 4; k++) begin
            n_chk++;
            if (obs[k] !== 16'h0000) begin
                n_fail++;
                $display("FAIL r0_pre port%0d: got %h want 0000", k, obs[k]);
            end
        end
        step();
        bus0.reg_write = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_chk++;
            if (obs[k] !== 16'h0000) begin
                n_fail++;
                $display("FAIL r0_post port%0d: got %h want 0000", k, obs[k]);
            end
        end
    endtask

    task automatic test_we_low();
        wr_reg(3'd2, 16'h00AA);
        bus0.reg_write = 1'b0;
        bus0.write_reg = 3'd2;
        bus0.write_data = 16'h5555;
        bus0.read_reg1 = 3'd2;
        bus0.read_reg2 = 3'd2;
        step();
        for (int k = 0; k < 4; k++) begin
            n_chk++;
            if (obs[k] !== 16'h00AA) begin
                n_fail++;
                $display("FAIL we_low port%0d: got %h want 00aa", k, obs[k]);
            end
        end
    endtask

    task automatic test_hazard();
        logic [15:0] e;
        wr_reg(3'd4, 16'd7);
        bus0.reg_write = 1'b1;
        bus0.write_reg = 3'd4;
        bus0.write_data = 16'd9;
        bus0.read_reg1 = 3'd4;
        bus0.read_reg2 = 3'd5;
        #1;
        for (int k = 0; k < 4; k++) begin
            e = k[0] ? 16'd1234 : (k >= 2 ? 16'd9 : 16'd7);
            n_chk++;
            if (obs[k] !== e) begin
                n_fail++;
                $display("FAIL hazard_pre port%0d: got %0d want %0d", k, obs[k], e);
            end
        end
        step();
        bus0.reg_write = 1'b0;
        #1;
        for (int k = 0; k < 4; k += 2) begin
            n_chk++;
            if (obs[k] !== 16'd9) begin
                n_fail++;
                $display("FAIL hazard_post port%0d: got %0d want 9", k, obs[k]);
            end
        end
    endtask

    task automatic test_collision();
        wr_reg(3'd6, 16'd42);
        rst = 1'b1;
        bus0.reg_write = 1'b1;
        bus0.write_reg = 3'd6;
        bus0.write_data = 16'd99;
        bus0.read_reg1 = 3'd6;
        bus0.read_reg2 = 3'd6;
        step();
        rst = 1'b0;
        bus0.reg_write = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            n_chk++;
            if (obs[k] !== 16'd0) begin
                n_fail++;
                $display("FAIL collision port%0d: got %0d want 0", k, obs[k]);
            end
        end
        wr_reg(3'd6, 16'd99);
        for (int k = 0; k < 4; k++) begin
            n_chk++;
            if (obs[k] !== 16'd99) begin
                n_fail++;
                $display("FAIL collision_rewrite port%0d: got %0d want 99", k, obs[k]);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] e;
        for (int i = 0; i < 500; i++) begin
            rst = ($urandom_range(0, 39) == 0);
            bus0.reg_write = 1'($urandom_range(0, 1));
            bus0.write_reg = 3'($urandom);
            bus0.write_data = 16'($urandom);
            bus0.read_reg1 = 3'($urandom);
            bus0.read_reg2 = ($urandom_range(0, 3) == 0) ? bus0.write_reg : 3'($urandom);
            #1;
            for (int k = 0; k < 4; k++) begin
                e = exp_rd(k[0] ? bus0.read_reg2 : bus0.read_reg1, k >= 2);
                n_chk++;
                if (obs[k] !== e) begin
                    n_fail++;
                    $display("FAIL random it%0d port%0d: got %h want %h", i, k, obs[k], e);
                end
            end
            step();
        end
        rst = 1'b0;
        bus0.reg_write = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) m[i] = 16'h0000;
        rst = 1'b1;
        bus0.reg_write = 1'b0;
        bus0.write_reg = 3'd0;
        bus0.write_data = 16'h0000;
        bus0.read_reg1 = 3'd0;
        bus0.read_reg2 = 3'd0;
        step();
        step();
        rst = 1'b0;
        test_reset();
        test_basic();
        test_r0();
        test_we_low();
        test_hazard();
        test_collision();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
